// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start/data/parity/stop framing into an N-bit hold
// register with a VALID/ACK handshake and parity, framing and overrun flags.
module serial_frame_rx #(
  parameter int N         = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic         clk,
  input  logic         RESET,
  input  logic         BIT_EN,
  input  logic         S_IN,
  input  logic         DIR,
  input  logic         ACK,
  output logic [N-1:0] DATA,
  output logic         VALID,
  output logic         PAR_ERR,
  output logic         FRM_ERR,
  output logic         OVERRUN,
  output logic         BUSY
);

  localparam int CW = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [CW-1:0]  cnt_r;
  logic [N-1:0]   sr_r;
  logic           dir_r;
  logic           pbit_r;
  logic [N-1:0]   data_r;
  logic           valid_r;
  logic           par_err_r;
  logic           frm_err_r;
  logic           overrun_r;
  logic           busy_r;
  logic           start_s;
  logic           shift_s;
  logic           par_s;
  logic           stop_s;
  logic           last_bit_s;

  // Even parity over data plus parity bit; 1 means the frame is corrupt.
  function automatic logic frame_par_err(input logic [N-1:0] d, input logic p);
    return (^d) ^ p;
  endfunction

  assign last_bit_s = (cnt_r == CW'(N - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; every transition is gated by the bit strobe.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (BIT_EN && !S_IN) state_nxt_s = ST_DATA;
        else                 state_nxt_s = ST_IDLE;
      end
      ST_DATA: begin
        if (BIT_EN && last_bit_s) state_nxt_s = PARITY_EN ? ST_PARITY : ST_STOP;
        else                      state_nxt_s = ST_DATA;
      end
      ST_PARITY: begin
        if (BIT_EN) state_nxt_s = ST_STOP;
        else        state_nxt_s = ST_PARITY;
      end
      ST_STOP: begin
        if (BIT_EN) state_nxt_s = ST_IDLE;
        else        state_nxt_s = ST_STOP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Per-state datapath strobes.
  always_comb begin
    start_s = 1'b0;
    shift_s = 1'b0;
    par_s   = 1'b0;
    stop_s  = 1'b0;
    case (state_r)
      ST_IDLE:   start_s = BIT_EN && !S_IN;
      ST_DATA:   shift_s = BIT_EN;
      ST_PARITY: par_s   = BIT_EN;
      ST_STOP:   stop_s  = BIT_EN;
      default:   start_s = 1'b0;
    endcase
  end

  // Shift register, bit counter and latched direction for the current frame.
  always_ff @(posedge clk) begin
    if (RESET) begin
      sr_r   <= '0;
      cnt_r  <= '0;
      dir_r  <= 1'b0;
      pbit_r <= 1'b0;
    end else if (start_s) begin
      sr_r   <= '0;
      cnt_r  <= '0;
      dir_r  <= DIR;
      pbit_r <= 1'b0;
    end else if (shift_s) begin
      sr_r  <= dir_r ? {S_IN, sr_r[N-1:1]} : {sr_r[N-2:0], S_IN};
      cnt_r <= cnt_r + CW'(1);
    end else if (par_s) begin
      pbit_r <= S_IN;
    end
  end

  // Hold register and handshake; a completion with ACK counts as a fresh load.
  always_ff @(posedge clk) begin
    if (RESET) begin
      data_r    <= '0;
      valid_r   <= 1'b0;
      par_err_r <= 1'b0;
      frm_err_r <= 1'b0;
      overrun_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != ST_IDLE);
      if (stop_s) begin
        if (!valid_r || ACK) begin
          data_r    <= sr_r;
          par_err_r <= PARITY_EN ? frame_par_err(sr_r, pbit_r) : 1'b0;
          frm_err_r <= !S_IN;
          valid_r   <= 1'b1;
          if (ACK) overrun_r <= 1'b0;
        end else begin
          overrun_r <= 1'b1;
        end
      end else if (ACK) begin
        valid_r   <= 1'b0;
        par_err_r <= 1'b0;
        frm_err_r <= 1'b0;
        overrun_r <= 1'b0;
      end
    end
  end

  assign DATA    = data_r;
  assign VALID   = valid_r;
  assign PAR_ERR = par_err_r;
  assign FRM_ERR = frm_err_r;
  assign OVERRUN = overrun_r;
  assign BUSY    = busy_r;

endmodule
